sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like bus port between instruction fetch (inst) and the memory stage (data).
- One outstanding transaction at a time; data side has priority, with a starvation guard for fetch.
- Registers the granted request, sequences the addr/data handshakes and routes read data back to the owner.
- Produces mem_stall for the pipeline while a data access is unfinished.

---
 rtl/sram_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter sharing one SRAM-like bus between fetch (inst) and memory stage (data).
// Optional performance counters are compiled in with ARB_PERF_CNT_EN.
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  output logic [31:0] perf_inst_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_conflicts
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;  // 1 = data side owns the bus
  logic               wr_reg, wr_next;
  logic [1:0]         size_reg, size_next;
  logic [3:0]         wstrb_reg, wstrb_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;

  logic at_limit;
  logic conflict;
  logic grant_data;
  logic grant_inst;
  logic resp;

  assign at_limit   = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
  assign conflict   = (state_reg == IDLE) && inst_req && data_req;
  assign grant_data = (state_reg == IDLE) && data_req && !(inst_req && at_limit);
  assign grant_inst = (state_reg == IDLE) && inst_req && !grant_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      wstrb_reg      <= 4'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      wr_reg         <= wr_next;
      size_reg       <= size_next;
      wstrb_reg      <= wstrb_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    wr_next         = wr_reg;
    size_next       = size_reg;
    wstrb_next      = wstrb_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    starve_cnt_next = starve_cnt_reg;
    resp            = 1'b0;
    inst_addr_ok    = 1'b0;
    inst_data_ok    = 1'b0;
    inst_rdata      = 32'd0;
    data_addr_ok    = 1'b0;
    data_data_ok    = 1'b0;
    data_rdata      = 32'd0;
    bus_req         = 1'b0;
    bus_wr          = 1'b0;
    bus_size        = 2'd0;
    bus_wstrb       = 4'd0;
    bus_addr        = 32'd0;
    bus_wdata       = 32'd0;

    case (state_reg)
      IDLE: begin
        if (grant_data) begin
          state_next = ADDR;
          owner_next = 1'b1;
          wr_next    = data_wr;
          size_next  = data_size;
          wstrb_next = data_wstrb;
          addr_next  = data_addr;
          wdata_next = data_wdata;
          if (conflict) starve_cnt_next = starve_cnt_reg + 1'b1;
        end else if (grant_inst) begin
          state_next      = ADDR;
          owner_next      = 1'b0;
          wr_next         = 1'b0;
          size_next       = 2'd2;
          wstrb_next      = 4'd0;
          addr_next       = inst_addr;
          wdata_next      = 32'd0;
          starve_cnt_next = '0;
        end
      end
      ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = wr_reg;
        bus_size  = size_reg;
        bus_wstrb = wstrb_reg;
        bus_addr  = addr_reg;
        bus_wdata = wdata_reg;
        if (bus_addr_ok) begin
          data_addr_ok = owner_reg;
          inst_addr_ok = !owner_reg;
          // A same-cycle slave completes the whole transaction here.
          if (bus_data_ok) begin
            resp       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          resp       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (resp) begin
      data_data_ok = owner_reg;
      inst_data_ok = !owner_reg;
      data_rdata   = owner_reg ? bus_rdata : 32'd0;
      inst_rdata   = owner_reg ? 32'd0 : bus_rdata;
    end

    mem_stall = (data_req || (owner_reg && (state_reg != IDLE))) && !data_data_ok;
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_reg;
  logic [31:0] perf_data_reg;
  logic [31:0] perf_conf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_reg <= 32'd0;
      perf_data_reg <= 32'd0;
      perf_conf_reg <= 32'd0;
    end else begin
      if (grant_inst) perf_inst_reg <= perf_inst_reg + 32'd1;
      if (grant_data) perf_data_reg <= perf_data_reg + 32'd1;
      if (conflict)   perf_conf_reg <= perf_conf_reg + 32'd1;
    end
  end

  assign perf_inst_grants = perf_inst_reg;
  assign perf_data_grants = perf_data_reg;
  assign perf_conflicts   = perf_conf_reg;
`else
  assign perf_inst_grants = 32'd0;
  assign perf_data_grants = 32'd0;
  assign perf_conflicts   = 32'd0;
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: loads, stores, fetch, starvation order, reset abandon, counters.
module tb_sram_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] perf_inst_grants, perf_data_grants, perf_conflicts;

  int n_checks = 0;
  int n_fail   = 0;

  sram_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expects to start in an IDLE cycle with both requests held; starve count must be 0.
  task automatic run_grants(input int n);
    logic [31:0] want;
    for (int k = 0; k < n; k++) begin
      tick();
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b1;
      #1;
      want = (k % 5 == 4) ? 32'd1 : 32'd2;  // 2 = data wins, 1 = inst wins
      chk($sformatf("grant%0d", k), {30'd0, data_addr_ok, inst_addr_ok}, want);
      $display("grant %0d: data_addr_ok=%0b inst_addr_ok=%0b", k, data_addr_ok, inst_addr_ok);
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_rdata = 0; bus_addr_ok = 0; bus_data_ok = 0;
    tick();
    tick();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    chk("rst_perf", perf_inst_grants | perf_data_grants | perf_conflicts, 32'd0);
    reset = 1'b0;

    // Single load with a slave answering addr_ok after one cycle and data a cycle later
    data_req = 1; data_addr = 32'h10;
    #1;
    chk("ld_stall_pre", {31'd0, mem_stall}, 32'd1);
    chk("ld_bus_req_pre", {31'd0, bus_req}, 32'd0);
    tick();
    bus_data_ok = 1;
    #1;
    chk("ld_bus_req", {31'd0, bus_req}, 32'd1);
    chk("ld_bus_addr", bus_addr, 32'h10);
    chk("ld_addr_ok_wait", {31'd0, data_addr_ok}, 32'd0);
    chk("ld_early_dok", {31'd0, data_data_ok}, 32'd0);
    tick();
    bus_data_ok = 0; bus_addr_ok = 1;
    #1;
    chk("ld_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("ld_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 0; bus_rdata = 32'h5555AAAA;
    #1;
    chk("ld_data_bus_req", {31'd0, bus_req}, 32'd0);
    chk("ld_data_stall", {31'd0, mem_stall}, 32'd1);
    chk("ld_stray_aok", {31'd0, data_addr_ok}, 32'd0);
    chk("ld_rdata_gated", data_rdata, 32'd0);
    bus_addr_ok = 0;
    tick();
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_dok", {31'd0, data_data_ok}, 32'd1);
    chk("ld_rdata", data_rdata, 32'hDEADBEEF);
    chk("ld_stall_done", {31'd0, mem_stall}, 32'd0);
    chk("ld_inst_dok", {31'd0, inst_data_ok}, 32'd0);
    chk("ld_inst_rdata", inst_rdata, 32'd0);
    tick();
    bus_data_ok = 0;
    #1;
    chk("ld_idle_dok", {31'd0, data_data_ok}, 32'd0);
    chk("ld_idle_stall", {31'd0, mem_stall}, 32'd0);
    $display("single load: rdata routed, mem_stall released");

    // Store with same-cycle slave
    data_req = 1; data_wr = 1; data_size = 2'd1; data_wstrb = 4'b0011;
    data_wdata = 32'h12345678; data_addr = 32'h20;
    tick();
    #1;
    chk("st_bus_req", {31'd0, bus_req}, 32'd1);
    chk("st_bus_wr", {31'd0, bus_wr}, 32'd1);
    chk("st_bus_size", {30'd0, bus_size}, 32'd1);
    chk("st_bus_wstrb", {28'd0, bus_wstrb}, 32'd3);
    chk("st_bus_addr", bus_addr, 32'h20);
    chk("st_bus_wdata", bus_wdata, 32'h12345678);
    bus_addr_ok = 1; bus_data_ok = 1;
    #1;
    chk("st_aok_dok", {30'd0, data_addr_ok, data_data_ok}, 32'd3);
    chk("st_inst_quiet", {30'd0, inst_addr_ok, inst_data_ok}, 32'd0);
    tick();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    #1;
    chk("st_back_idle", {31'd0, bus_req}, 32'd0);
    $display("store: fields routed, same-cycle completion");

    // Fetch: data fields left stale to show inst grants force wr/size/wstrb
    inst_req = 1; inst_addr = 32'h100;
    tick();
    #1;
    chk("if_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("if_bus_size", {30'd0, bus_size}, 32'd2);
    chk("if_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("if_bus_addr", bus_addr, 32'h100);
    chk("if_stall", {31'd0, mem_stall}, 32'd0);
    bus_addr_ok = 1;
    #1;
    chk("if_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
    #1;
    chk("if_dok", {31'd0, inst_data_ok}, 32'd1);
    chk("if_rdata", inst_rdata, 32'hCAFEF00D);
    chk("if_data_rdata", data_rdata, 32'd0);
    chk("if_data_dok", {31'd0, data_data_ok}, 32'd0);
    tick();
    bus_data_ok = 0;
    $display("fetch: forced word read, rdata routed to inst");

    // Starvation: both held, expect D,D,D,D,I twice
    data_wr = 0; data_size = 2'd2; data_wstrb = 0;
    inst_req = 1; data_req = 1;
    #1;
    run_grants(10);
    inst_req = 0; data_req = 0;

    // Reset in DATA after a conflict win; starve count must restart from 0
    inst_req = 1; data_req = 1;
    tick();
    bus_addr_ok = 1;
    #1;
    chk("rm_aok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    bus_addr_ok = 0; reset = 1;
    tick();
    reset = 0; bus_data_ok = 1; bus_rdata = 32'hBAD0BAD0;
    #1;
    chk("rm_no_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rm_rdata", data_rdata | inst_rdata, 32'd0);
    chk("rm_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rm_stall", {31'd0, mem_stall}, 32'd1);
    chk("rm_perf", perf_inst_grants | perf_data_grants | perf_conflicts, 32'd0);
    $display("reset mid-op: late data_ok ignored");
    bus_data_ok = 0;
    run_grants(5);
    inst_req = 0; data_req = 0;

    // Counters: 3 conflicts then 2 inst-only grants
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("pf_rst", perf_inst_grants | perf_data_grants | perf_conflicts, 32'd0);
    inst_req = 1; data_req = 1;
    run_grants(3);
    data_req = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus_addr_ok = 1; bus_data_ok = 1;
      #1;
      chk("pf_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
      tick();
      bus_addr_ok = 0; bus_data_ok = 0;
    end
    inst_req = 0;
    #1;
`ifdef ARB_PERF_CNT_EN
    chk("pf_conflicts", perf_conflicts, 32'd3);
    chk("pf_inst", perf_inst_grants, 32'd2);
    chk("pf_data", perf_data_grants, 32'd3);
`else
    chk("pf_tied", perf_inst_grants | perf_data_grants | perf_conflicts, 32'd0);
`endif
    $display("perf: conflicts=%0d inst=%0d data=%0d", perf_conflicts, perf_inst_grants, perf_data_grants);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
